// File: rtl/gpu_cmd_host.sv
// Host-side command port to a GPU: sends one command per request over a strobed bus and,
// for reads, waits for the GPU's return strobe (with a timeout) before reporting completion.
module gpu_cmd_host #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk_in,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_read,
  input  logic [7:0]  req_cmd,
  input  logic [15:0] req_data,
  output logic        resp_valid,
  output logic [15:0] resp_data,
  output logic        resp_timeout,
  output logic        cmd_clk_out,
  output logic        cmd_inout,
  output logic [7:0]  command_o,
  output logic        command_oe,
  output logic [15:0] commandData_o,
  output logic        commandData_oe,
  input  logic [15:0] commandData_i,
  input  logic        gpu_clk_in
);

  localparam logic [7:0]  DivLoad     = 8'(CLK_DIV - 1);
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStrobe,
    StHold,
    StTurn,
    StWaitRd
  } state_e;

  state_e      r_state, w_state_nxt;
  logic [7:0]  r_div_cnt, w_div_cnt_nxt;
  logic [15:0] r_wait_cnt, w_wait_cnt_nxt;
  logic        r_read, w_read_nxt;
  logic [7:0]  r_cmd, w_cmd_nxt;
  logic [15:0] r_data, w_data_nxt;
  logic        r_cmd_clk, w_cmd_clk_nxt;
  logic        r_inout, w_inout_nxt;
  logic        r_cmd_oe, w_cmd_oe_nxt;
  logic        r_data_oe, w_data_oe_nxt;
  logic        r_resp_valid, w_resp_valid_nxt;
  logic [15:0] r_resp_data, w_resp_data_nxt;
  logic        r_resp_timeout, w_resp_timeout_nxt;

  logic        r_sync1, r_sync2, r_sync3;
  logic        w_gpu_edge;

  // The delay flop runs every cycle, so an edge completing in TURN is consumed before WAIT_RD.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= gpu_clk_in;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_gpu_edge = r_sync2 & ~r_sync3;

  assign req_ready = reset_n & (r_state == StIdle);

  always_comb begin
    w_state_nxt        = r_state;
    w_div_cnt_nxt      = r_div_cnt;
    w_wait_cnt_nxt     = r_wait_cnt;
    w_read_nxt         = r_read;
    w_cmd_nxt          = r_cmd;
    w_data_nxt         = r_data;
    w_cmd_clk_nxt      = r_cmd_clk;
    w_inout_nxt        = r_inout;
    w_cmd_oe_nxt       = r_cmd_oe;
    w_data_oe_nxt      = r_data_oe;
    w_resp_valid_nxt   = 1'b0;
    w_resp_data_nxt    = r_resp_data;
    w_resp_timeout_nxt = r_resp_timeout;

    case (r_state)
      StIdle: begin
        if (req_valid && req_ready) begin
          w_state_nxt   = StSetup;
          w_div_cnt_nxt = DivLoad;
          w_read_nxt    = req_read;
          w_cmd_nxt     = req_cmd;
          w_data_nxt    = req_data;
          w_inout_nxt   = req_read;
          w_cmd_clk_nxt = 1'b0;
          w_cmd_oe_nxt  = 1'b1;
          w_data_oe_nxt = ~req_read;
        end
      end
      StSetup: begin
        if (r_div_cnt == 8'd0) begin
          w_state_nxt   = StStrobe;
          w_div_cnt_nxt = DivLoad;
          w_cmd_clk_nxt = 1'b1;
        end else begin
          w_div_cnt_nxt = r_div_cnt - 8'd1;
        end
      end
      StStrobe: begin
        if (r_div_cnt == 8'd0) begin
          w_state_nxt   = StHold;
          w_div_cnt_nxt = DivLoad;
          w_cmd_clk_nxt = 1'b0;
        end else begin
          w_div_cnt_nxt = r_div_cnt - 8'd1;
        end
      end
      StHold: begin
        if (r_div_cnt == 8'd0) begin
          w_data_oe_nxt = 1'b0;
          if (r_read) begin
            w_state_nxt = StTurn;
          end else begin
            w_state_nxt        = StIdle;
            w_cmd_oe_nxt       = 1'b0;
            w_resp_valid_nxt   = 1'b1;
            w_resp_data_nxt    = 16'h0000;
            w_resp_timeout_nxt = 1'b0;
          end
        end else begin
          w_div_cnt_nxt = r_div_cnt - 8'd1;
        end
      end
      StTurn: begin
        w_state_nxt    = StWaitRd;
        w_wait_cnt_nxt = 16'd0;
      end
      StWaitRd: begin
        // A return strobe takes priority over an expiring timeout in the same cycle.
        if (w_gpu_edge) begin
          w_state_nxt        = StIdle;
          w_cmd_oe_nxt       = 1'b0;
          w_resp_valid_nxt   = 1'b1;
          w_resp_data_nxt    = commandData_i;
          w_resp_timeout_nxt = 1'b0;
        end else if (r_wait_cnt == TimeoutLast) begin
          w_state_nxt        = StIdle;
          w_cmd_oe_nxt       = 1'b0;
          w_resp_valid_nxt   = 1'b1;
          w_resp_data_nxt    = 16'h0000;
          w_resp_timeout_nxt = 1'b1;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + 16'd1;
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= StIdle;
      r_div_cnt      <= 8'd0;
      r_wait_cnt     <= 16'd0;
      r_read         <= 1'b0;
      r_cmd          <= 8'h00;
      r_data         <= 16'h0000;
      r_cmd_clk      <= 1'b0;
      r_inout        <= 1'b0;
      r_cmd_oe       <= 1'b0;
      r_data_oe      <= 1'b0;
      r_resp_valid   <= 1'b0;
      r_resp_data    <= 16'h0000;
      r_resp_timeout <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_div_cnt      <= w_div_cnt_nxt;
      r_wait_cnt     <= w_wait_cnt_nxt;
      r_read         <= w_read_nxt;
      r_cmd          <= w_cmd_nxt;
      r_data         <= w_data_nxt;
      r_cmd_clk      <= w_cmd_clk_nxt;
      r_inout        <= w_inout_nxt;
      r_cmd_oe       <= w_cmd_oe_nxt;
      r_data_oe      <= w_data_oe_nxt;
      r_resp_valid   <= w_resp_valid_nxt;
      r_resp_data    <= w_resp_data_nxt;
      r_resp_timeout <= w_resp_timeout_nxt;
    end
  end

  assign cmd_clk_out    = r_cmd_clk;
  assign cmd_inout      = r_inout;
  assign command_o      = r_cmd;
  assign command_oe     = r_cmd_oe;
  assign commandData_o  = r_data;
  assign commandData_oe = r_data_oe;
  assign resp_valid     = r_resp_valid;
  assign resp_data      = r_resp_data;
  assign resp_timeout   = r_resp_timeout;

endmodule
